hilo_md_ctrl: RTL and testbench

- Sequencer for the HI/LO multiply/divide resource feeding the M/E writeback select path.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the M stage.
- Runs multiply over a fixed latency and divide as a 32-step restoring iteration.
- Stalls the pipeline while busy, commits HI/LO on completion and serves MFHI/MFLO reads through hilo_data_out.

---
 rtl/hilo_md_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_hilo_md_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: HI/LO multiply/divide sequencer.
//
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the M stage. Multiply runs for a
// fixed MUL_CYCLES compute cycles. Divide runs as a 32-step restoring iteration
// on magnitudes, with the sign fixed up at commit. The pipeline is stalled while
// an op is in flight. HI/LO commit in the DONE state with a one-cycle md_done.
//
// Optional feature (macro HILO_BYPASS_EN): when defined, hilo_data_out forwards
// in-cycle HI/LO write data. When undefined, reads see only the registered HI/LO.
//
// Ports:
//   clk           pipeline clock
//   reset         synchronous, active-high
//   md_valid      md_op valid this cycle
//   md_op         000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//                 101 MTHI, 110 MTLO, 111 none
//   src_a         rs operand (dividend / multiplicand / MTHI-MTLO data)
//   src_b         rt operand (divisor / multiplier)
//   flush         cancels any in-flight op; highest priority
//   hilo_sel      read select: 0 = LO, 1 = HI
//   hilo_data_out selected HI/LO value
//   stall_req     hold the pipeline
//   md_done       one-cycle pulse on HI/LO commit of MULT/DIV
module hilo_md_ctrl #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        hilo_sel,
  output logic [31:0] hilo_data_out,
  output logic        stall_req,
  output logic        md_done
);

  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpDivu  = 3'b100;
  localparam logic [2:0] OpMthi  = 3'b101;
  localparam logic [2:0] OpMtlo  = 3'b110;

  localparam logic [5:0] MulLast = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DivLast = 6'd31;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } stateT;

  stateT       stateQ, stateD;
  logic [31:0] hiQ, hiD;
  logic [31:0] loQ, loD;
  logic [5:0]  countQ, countD;
  // opA: multiplicand, or dividend magnitude that becomes the quotient.
  // opB: multiplier, or divisor magnitude.
  logic [31:0] opAQ, opAD;
  logic [31:0] opBQ, opBD;
  logic [32:0] remQ, remD;
  logic [63:0] prodQ, prodD;
  logic        isDivQ, isDivD;
  logic        mulSignedQ, mulSignedD;
  logic        negQuotQ, negQuotD;
  logic        negRemQ, negRemD;

  // Multiply datapath: sign-extend to 64 bits so one unsigned multiplier's low
  // 64 bits serve both MULT and MULTU.
  logic [63:0] mulExtA, mulExtB, mulFull;

  always_comb begin
    mulExtA = {{32{mulSignedQ & opAQ[31]}}, opAQ};
    mulExtB = {{32{mulSignedQ & opBQ[31]}}, opBQ};
    mulFull = mulExtA * mulExtB;
  end

  // Restoring divide step. The remainder stays below the divisor, so bit 32 of
  // the difference is set exactly when the trial subtraction borrows.
  logic [32:0] divShift, divDiff;
  logic        divFits;

  always_comb begin
    divShift = {remQ[31:0], opAQ[31]};
    divDiff  = divShift - {1'b0, opBQ};
    divFits  = ~divDiff[32];
  end

  // Values committed in DONE, with the divide sign fix applied.
  logic [31:0] quoFix, remFix, commitHi, commitLo;

  always_comb begin
    quoFix   = negQuotQ ? (~opAQ + 32'd1) : opAQ;
    remFix   = negRemQ ? (~remQ[31:0] + 32'd1) : remQ[31:0];
    commitHi = isDivQ ? remFix : prodQ[63:32];
    commitLo = isDivQ ? quoFix : prodQ[31:0];
  end

  // Operand magnitudes for a divide about to be accepted.
  logic        divSigned;
  logic [31:0] absA, absB;

  always_comb begin
    divSigned = (md_op == OpDiv);
    absA      = (divSigned & src_a[31]) ? (~src_a + 32'd1) : src_a;
    absB      = (divSigned & src_b[31]) ? (~src_b + 32'd1) : src_b;
  end

  always_comb begin
    stateD     = stateQ;
    hiD        = hiQ;
    loD        = loQ;
    countD     = countQ;
    opAD       = opAQ;
    opBD       = opBQ;
    remD       = remQ;
    prodD      = prodQ;
    isDivD     = isDivQ;
    mulSignedD = mulSignedQ;
    negQuotD   = negQuotQ;
    negRemD    = negRemQ;
    stall_req  = 1'b0;
    md_done    = 1'b0;

    if (flush) begin
      stateD = StIdle;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (md_valid) begin
            case (md_op)
              OpMult, OpMultu: begin
                stall_req  = 1'b1;
                opAD       = src_a;
                opBD       = src_b;
                mulSignedD = (md_op == OpMult);
                isDivD     = 1'b0;
                countD     = '0;
                stateD     = StMul;
              end
              OpDiv, OpDivu: begin
                // Divide by zero is dropped: no stall, HI/LO untouched.
                if (src_b != 32'd0) begin
                  stall_req = 1'b1;
                  opAD      = absA;
                  opBD      = absB;
                  negQuotD  = divSigned & (src_a[31] ^ src_b[31]);
                  negRemD   = divSigned & src_a[31];
                  remD      = '0;
                  isDivD    = 1'b1;
                  countD    = '0;
                  stateD    = StDiv;
                end
              end
              OpMthi:  hiD = src_a;
              OpMtlo:  loD = src_a;
              default: ;
            endcase
          end
        end
        StMul: begin
          stall_req = 1'b1;
          countD    = countQ + 6'd1;
          if (countQ == MulLast) begin
            prodD  = mulFull;
            stateD = StDone;
          end
        end
        StDiv: begin
          stall_req = 1'b1;
          remD      = divFits ? divDiff : divShift;
          opAD      = {opAQ[30:0], divFits};
          countD    = countQ + 6'd1;
          if (countQ == DivLast) begin
            stateD = StDone;
          end
        end
        StDone: begin
          // md_valid here belongs to the instruction just released; ignore it.
          hiD     = commitHi;
          loD     = commitLo;
          md_done = 1'b1;
          stateD  = StIdle;
        end
        default: stateD = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ     <= StIdle;
      hiQ        <= '0;
      loQ        <= '0;
      countQ     <= '0;
      opAQ       <= '0;
      opBQ       <= '0;
      remQ       <= '0;
      prodQ      <= '0;
      isDivQ     <= 1'b0;
      mulSignedQ <= 1'b0;
      negQuotQ   <= 1'b0;
      negRemQ    <= 1'b0;
    end else begin
      stateQ     <= stateD;
      hiQ        <= hiD;
      loQ        <= loD;
      countQ     <= countD;
      opAQ       <= opAD;
      opBQ       <= opBD;
      remQ       <= remD;
      prodQ      <= prodD;
      isDivQ     <= isDivD;
      mulSignedQ <= mulSignedD;
      negQuotQ   <= negQuotD;
      negRemQ    <= negRemD;
    end
  end

  always_comb begin
    hilo_data_out = hilo_sel ? hiQ : loQ;
`ifdef HILO_BYPASS_EN
    if (!flush) begin
      if (stateQ == StIdle && md_valid) begin
        if (md_op == OpMthi && hilo_sel) begin
          hilo_data_out = src_a;
        end else if (md_op == OpMtlo && !hilo_sel) begin
          hilo_data_out = src_a;
        end
      end else if (stateQ == StDone) begin
        hilo_data_out = hilo_sel ? commitHi : commitLo;
      end
    end
`endif
  end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
module tb_hilo_md_ctrl;

  localparam int unsigned MulCycles = 2;

  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpDivu  = 3'b100;
  localparam logic [2:0] OpMthi  = 3'b101;
  localparam logic [2:0] OpMtlo  = 3'b110;

  logic        clk;
  logic        reset;
  logic        md_valid;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        hilo_sel;
  logic [31:0] hilo_data_out;
  logic        stall_req;
  logic        md_done;

  hilo_md_ctrl #(
    .MUL_CYCLES(MulCycles)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .md_valid     (md_valid),
    .md_op        (md_op),
    .src_a        (src_a),
    .src_b        (src_b),
    .flush        (flush),
    .hilo_sel     (hilo_sel),
    .hilo_data_out(hilo_data_out),
    .stall_req    (stall_req),
    .md_done      (md_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;

  // Scoreboard of expected {HI, LO} for each MULT/DIV expected to commit.
  logic [31:0] sbHi[$];
  logic [31:0] sbLo[$];

  logic [31:0] curHi, curLo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called with md_valid low, mid-cycle; HI/LO output is purely registered then.
  task automatic readHiLo(input string tag, input logic [31:0] expHi, input logic [31:0] expLo);
    hilo_sel = 1'b1;
    #1;
    check({tag, "_hi"}, hilo_data_out, expHi);
    hilo_sel = 1'b0;
    #1;
    check({tag, "_lo"}, hilo_data_out, expLo);
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int expStall,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    int  stalls;
    bit  seen;
    logic [31:0] hiE, loE;
    sbHi.push_back(expHi);
    sbLo.push_back(expLo);
    @(posedge clk); #1;
    md_valid = 1'b1;
    md_op    = op;
    src_a    = a;
    src_b    = b;
    stalls   = 0;
    seen     = 0;
    for (int cyc = 0; cyc < 80 && !seen; cyc++) begin
      @(negedge clk);
      if (stall_req) stalls++;
      if (md_done) seen = 1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_stalls"}, 64'(stalls), 64'(expStall));
    @(posedge clk); #1;
    md_valid = 1'b0;
    md_op    = 3'b000;
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(md_done), 64'd0);
    hiE = sbHi.pop_front();
    loE = sbLo.pop_front();
    readHiLo(tag, hiE, loE);
    curHi = hiE;
    curLo = loE;
  endtask

  task automatic mtOp(input string tag, input logic [2:0] op, input logic [31:0] data,
                      input logic fl);
    @(posedge clk); #1;
    md_valid = 1'b1;
    md_op    = op;
    src_a    = data;
    flush    = fl;
    @(negedge clk);
    check({tag, "_stall"}, 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    md_valid = 1'b0;
    md_op    = 3'b000;
    flush    = 1'b0;
    if (!fl) begin
      if (op == OpMthi) curHi = data;
      else curLo = data;
    end
    @(negedge clk);
    readHiLo(tag, curHi, curLo);
  endtask

  initial begin
    int doneCnt;
    reset    = 1'b1;
    md_valid = 1'b0;
    md_op    = 3'b000;
    src_a    = '0;
    src_b    = '0;
    flush    = 1'b0;
    hilo_sel = 1'b0;
    curHi    = '0;
    curLo    = '0;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_done", 64'(md_done), 64'd0);
    readHiLo("rst", 32'h0, 32'h0);

    runOp("mult_neg", OpMult, 32'hFFFF_FFFD, 32'd5, MulCycles + 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    runOp("divu", OpDivu, 32'd100, 32'd7, 33, 32'd2, 32'd14);

    mtOp("mthi", OpMthi, 32'h1111_1111, 1'b0);
    mtOp("mtlo", OpMtlo, 32'h1111_1111, 1'b0);

    // DIV flushed at step 10: nothing commits.
    @(posedge clk); #1;
    md_valid = 1'b1;
    md_op    = OpDiv;
    src_a    = 32'hFFFF_FFF9;
    src_b    = 32'd2;
    @(negedge clk);
    check("flush_accept_stall", 64'(stall_req), 64'd1);
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("flush_step9_stall", 64'(stall_req), 64'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_cyc_stall", 64'(stall_req), 64'd0);
    check("flush_cyc_done", 64'(md_done), 64'd0);
    @(posedge clk); #1;
    flush    = 1'b0;
    md_valid = 1'b0;
    md_op    = 3'b000;
    @(negedge clk);
    check("flush_after_stall", 64'(stall_req), 64'd0);
    readHiLo("flush_hilo", 32'h1111_1111, 32'h1111_1111);
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md_done || stall_req) doneCnt++;
    end
    check("flush_quiet", 64'(doneCnt), 64'd0);

    mtOp("mthi_flushed", OpMthi, 32'h2222_2222, 1'b1);

    runOp("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // Divide by zero: dropped without a stall.
    @(posedge clk); #1;
    md_valid = 1'b1;
    md_op    = OpDiv;
    src_a    = 32'd5;
    src_b    = 32'd0;
    @(negedge clk);
    check("div0_stall", 64'(stall_req), 64'd0);
    check("div0_done", 64'(md_done), 64'd0);
    @(posedge clk); #1;
    md_valid = 1'b0;
    md_op    = 3'b000;
    @(negedge clk);
    check("div0_stall2", 64'(stall_req), 64'd0);
    check("div0_done2", 64'(md_done), 64'd0);
    readHiLo("div0", curHi, curLo);

    // MTLO read in the same cycle.
    @(posedge clk); #1;
    md_valid = 1'b1;
    md_op    = OpMtlo;
    src_a    = 32'hDEAD_BEEF;
    hilo_sel = 1'b0;
    @(negedge clk);
`ifdef HILO_BYPASS_EN
    check("mtlo_same_cyc", hilo_data_out, 32'hDEAD_BEEF);
`else
    check("mtlo_same_cyc", hilo_data_out, curLo);
`endif
    @(posedge clk); #1;
    md_valid = 1'b0;
    md_op    = 3'b000;
    curLo    = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mtlo_next_cyc", hilo_data_out, 32'hDEAD_BEEF);

    runOp("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
    runOp("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulCycles + 1,
          32'hFFFF_FFFE, 32'h0000_0001);

    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      int          ia, ib, q, r;
      longint      p;
      a  = $urandom;
      b  = $urandom;
      ia = a;
      ib = b;
      p  = longint'(ia) * longint'(ib);
      runOp("mult_rnd", OpMult, a, b, MulCycles + 1, p[63:32], p[31:0]);
      b  = $urandom_range(1, 32'h7FFF);
      if (i[0]) b = ~b + 32'd1;
      ib = b;
      q  = ia / ib;
      r  = ia % ib;
      runOp("div_rnd", OpDiv, a, b, 33, r, q);
      runOp("divu_rnd", OpDivu, a, b, 33, a % b, a / b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
